boot_image_loader: RTL and testbench

Byte-stream writer that programs an instruction/boot memory image. It accepts a framed image (magic, length, payload, checksum) over a valid/ready byte interface, assembles little-endian 32-bit words and writes them through a single synchronous write port. The memory it fills is the array later read by the processor fetch path. It sits between the host/debug link (UART or JTAG bridge) and the write port of the boot memory.

---
 rtl/boot_image_loader_if.sv | 23 ++
 rtl/boot_image_loader.sv | 173 +++++++++++++++++
 tb/tb_boot_image_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_image_loader_if.sv
// Byte-stream and memory write-port bundle for the boot image loader.
interface boot_image_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [7:0]            s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_din;

    // Loader side: consumes the stream, drives the memory write port.
    modport slave (
        input  s_data, s_valid,
        output s_ready, mem_we, mem_addr, mem_din
    );

    // Host/memory side.
    modport master (
        output s_data, s_valid,
        input  s_ready, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/boot_image_loader.sv
// Framed boot image loader: magic, length, little-endian payload words, checksum.
// Payload words are written to the boot memory as they complete.
module boot_image_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] MAGIC      = 32'hB00710AD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    boot_image_loader_if.slave    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   words_written
);
    localparam int unsigned CW  = ADDR_WIDTH + 1;
    localparam logic [32:0] CAP = 33'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, MAGIC_S, LEN, DATA, CSUM, DONE, ERR} state_t;

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           word_q, word_d;
    logic [CW-1:0]         len_q, len_d;
    logic [31:0]           csum_q, csum_d;
    logic [CW-1:0]         ww_q, ww_d;
    logic                  s_ready_q, s_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_din_q, mem_din_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  last_byte;
    logic [31:0]           full_word;
    logic [CW-1:0]         ww_inc;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        len_d      = len_q;
        csum_d     = csum_q;
        ww_d       = ww_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        last_byte  = 1'b0;
        full_word  = {bus.s_data, word_q[23:0]};
        ww_inc     = ww_q + CW'(1);

        if (bus.s_valid && s_ready_q) begin
            idx_d                      = idx_q + 2'd1;
            word_d[{idx_q, 3'b000} +: 8] = bus.s_data;
            last_byte                  = (idx_q == 2'd3);
        end

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = MAGIC_S;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = 2'd0;
                    ww_d       = '0;
                    csum_d     = '0;
                    idx_d      = '0;
                end
            end
            MAGIC_S: begin
                if (last_byte) begin
                    if (full_word == MAGIC) begin
                        state_d = LEN;
                    end else begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'd1;
                    end
                end
            end
            LEN: begin
                if (last_byte) begin
                    if (full_word == 32'd0 || {1'b0, full_word} > CAP) begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'd2;
                    end else begin
                        len_d   = CW'(full_word);
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (last_byte) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = ww_q[ADDR_WIDTH-1:0];
                    mem_din_d  = full_word;
                    csum_d     = csum_q + full_word;
                    ww_d       = ww_inc;
                    if (ww_inc == len_q) state_d = CSUM;
                end
            end
            CSUM: begin
                if (last_byte) begin
                    if (full_word == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'd3;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        s_ready_d = (state_d == MAGIC_S) || (state_d == LEN) ||
                    (state_d == DATA)    || (state_d == CSUM);
        busy_d    = s_ready_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            ww_q       <= '0;
            s_ready_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            ww_q       <= ww_d;
            s_ready_q  <= s_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_code       = err_code_q;
    assign words_written  = ww_q;
endmodule

// File: tb/tb_boot_image_loader.sv
// Directed bench: one loader with a 1K-word memory and one with 16 words share the stream.
module tb_boot_image_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] s_data;
    logic       s_valid;

    int total = 0;
    int bad   = 0;

    boot_image_loader_if #(.ADDR_WIDTH(10)) if_big ();
    boot_image_loader_if #(.ADDR_WIDTH(4))  if_small ();

    logic        b_busy, b_done, b_error;
    logic [1:0]  b_code;
    logic [10:0] b_ww;
    logic        m_busy, m_done, m_error;
    logic [1:0]  m_code;
    logic [4:0]  m_ww;

    assign if_big.s_data    = s_data;
    assign if_big.s_valid   = s_valid;
    assign if_small.s_data  = s_data;
    assign if_small.s_valid = s_valid;

    boot_image_loader #(.ADDR_WIDTH(10)) u_big (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(if_big),
        .busy(b_busy), .done(b_done), .error(b_error), .err_code(b_code), .words_written(b_ww)
    );

    boot_image_loader #(.ADDR_WIDTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(if_small),
        .busy(m_busy), .done(m_done), .error(m_error), .err_code(m_code), .words_written(m_ww)
    );

    always #5 clk = ~clk;

    // Write logs, sampled mid-cycle
    logic [9:0]  b_addr[$];
    logic [31:0] b_data[$];
    logic [3:0]  m_addr[$];
    logic [31:0] m_data[$];

    always @(negedge clk) begin
        if (if_big.mem_we === 1'b1) begin
            b_addr.push_back(if_big.mem_addr);
            b_data.push_back(if_big.mem_din);
        end
        if (if_small.mem_we === 1'b1) begin
            m_addr.push_back(if_small.mem_addr);
            m_data.push_back(if_small.mem_din);
        end
    end

    task automatic clear_logs();
        b_addr.delete(); b_data.delete(); m_addr.delete(); m_data.delete();
    endtask

    task automatic idle();
        @(posedge clk); @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_data = b; s_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(t[7:0]);
            t = t >> 8;
            if (gap > 0) repeat ($urandom_range(0, gap)) idle();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_good_frame(input logic [31:0] csum);
        send_word(32'hB00710AD, 0);
        send_word(32'd3, 0);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        send_word(32'h99AABBCC, 0);
        send_word(csum, 0);
    endtask

    task automatic test_reset();
        total++; if (if_big.s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%0b want=0", if_big.s_ready); end
        total++; if (if_big.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0b want=0", if_big.mem_we); end
        total++; if ({b_busy, b_done, b_error} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {b_busy, b_done, b_error}); end
        total++; if (b_code !== 2'd0) begin bad++; $display("FAIL reset_err_code got=%0d want=0", b_code); end
        total++; if (b_ww !== 11'd0) begin bad++; $display("FAIL reset_words_written got=%0d want=0", b_ww); end
        total++; if (if_big.mem_addr !== 10'd0 || if_big.mem_din !== 32'd0) begin bad++; $display("FAIL reset_mem_bus got=%h/%h want=0/0", if_big.mem_addr, if_big.mem_din); end
    endtask

    task automatic test_good_frame();
        clear_logs();
        pulse_start();
        total++; if (b_busy !== 1'b1 || if_big.s_ready !== 1'b1) begin bad++; $display("FAIL good_armed busy/ready got=%b%b want=11", b_busy, if_big.s_ready); end
        send_word(32'hB00710AD, 0);
        send_word(32'd3, 0);
        send_word(32'h11223344, 0);
        total++; if (if_big.mem_we !== 1'b1 || if_big.mem_addr !== 10'd0 || if_big.mem_din !== 32'h11223344)
            begin bad++; $display("FAIL good_first_write got=we%b @%0d %h want=we1 @0 11223344", if_big.mem_we, if_big.mem_addr, if_big.mem_din); end
        idle();
        total++; if (if_big.mem_we !== 1'b0 || if_big.mem_din !== 32'h11223344) begin bad++; $display("FAIL good_we_pulse got=we%b %h want=we0 11223344", if_big.mem_we, if_big.mem_din); end
        pulse_start();
        total++; if (b_ww !== 11'd1 || b_busy !== 1'b1) begin bad++; $display("FAIL good_start_ignored got=ww%0d busy%b want=ww1 busy1", b_ww, b_busy); end
        send_word(32'h55667788, 0);
        send_word(32'h99AABBCC, 0);
        total++; if (if_big.mem_we !== 1'b1 || if_big.s_ready !== 1'b1 || b_ww !== 11'd3)
            begin bad++; $display("FAIL good_last_write got=we%b rdy%b ww%0d want=we1 rdy1 ww3", if_big.mem_we, if_big.s_ready, b_ww); end
        send_word(32'h00336698, 0);
        total++; if ({b_done, b_error, b_busy, if_big.s_ready} !== 4'b1000)
            begin bad++; $display("FAIL good_done_flags got=%b want=1000", {b_done, b_error, b_busy, if_big.s_ready}); end
        idle(); idle();
        total++; if (b_done !== 1'b1 || b_ww !== 11'd3) begin bad++; $display("FAIL good_done_held got=done%b ww%0d want=done1 ww3", b_done, b_ww); end
        total++; if (b_addr.size() != 3) begin bad++; $display("FAIL good_write_count got=%0d want=3", b_addr.size()); end
        else if (b_addr[0] !== 10'd0 || b_data[0] !== 32'h11223344 || b_addr[1] !== 10'd1 || b_data[1] !== 32'h55667788 ||
                 b_addr[2] !== 10'd2 || b_data[2] !== 32'h99AABBCC)
            begin bad++; $display("FAIL good_write_data got=%h@%0d %h@%0d %h@%0d", b_data[0], b_addr[0], b_data[1], b_addr[1], b_data[2], b_addr[2]); end
        total++; if (m_done !== 1'b1 || m_ww !== 5'd3) begin bad++; $display("FAIL good_small got=done%b ww%0d want=done1 ww3", m_done, m_ww); end
    endtask

    task automatic test_bad_magic();
        clear_logs();
        pulse_start();
        total++; if (b_done !== 1'b0 || m_done !== 1'b0) begin bad++; $display("FAIL magic_start_clears_done got=%b%b want=00", b_done, m_done); end
        send_word(32'hB10710AD, 0);
        total++; if ({b_error, b_done, if_big.s_ready} !== 3'b100 || b_code !== 2'd1)
            begin bad++; $display("FAIL magic_error got=err%b done%b rdy%b code%0d want=err1 done0 rdy0 code1", b_error, b_done, if_big.s_ready, b_code); end
        send_byte(8'h00);
        total++; if (b_addr.size() != 0 || m_addr.size() != 0 || b_code !== 2'd1)
            begin bad++; $display("FAIL magic_no_write got=%0d/%0d code%0d want=0/0 code1", b_addr.size(), m_addr.size(), b_code); end
        pulse_start();
        total++; if ({b_error, b_done, b_busy} !== 3'b001 || b_code !== 2'd0)
            begin bad++; $display("FAIL magic_rearm got=err%b done%b busy%b code%0d want=0 0 1 0", b_error, b_done, b_busy, b_code); end
    endtask

    task automatic test_bad_length();
        clear_logs();
        send_word(32'hB00710AD, 0);
        send_word(32'd0, 0);
        total++; if (b_error !== 1'b1 || b_code !== 2'd2) begin bad++; $display("FAIL len_zero got=err%b code%0d want=err1 code2", b_error, b_code); end
        pulse_start();
        send_word(32'hB00710AD, 0);
        send_word(32'd1025, 0);
        total++; if (b_error !== 1'b1 || b_code !== 2'd2 || m_code !== 2'd2)
            begin bad++; $display("FAIL len_1025 got=err%b code%0d small%0d want=err1 code2 small2", b_error, b_code, m_code); end
        pulse_start();
        send_word(32'hB00710AD, 0);
        send_word(32'd17, 0);
        total++; if (m_error !== 1'b1 || m_code !== 2'd2 || b_error !== 1'b0 || b_busy !== 1'b1)
            begin bad++; $display("FAIL len_17 got=small err%b code%0d big err%b busy%b want=1 2 0 1", m_error, m_code, b_error, b_busy); end
        total++; if (b_addr.size() != 0 || m_addr.size() != 0) begin bad++; $display("FAIL len_no_write got=%0d/%0d want=0/0", b_addr.size(), m_addr.size()); end
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_csum_mismatch();
        clear_logs();
        pulse_start();
        send_good_frame(32'h00336699);
        total++; if ({b_error, b_done} !== 2'b10 || b_code !== 2'd3)
            begin bad++; $display("FAIL csum_error got=err%b done%b code%0d want=err1 done0 code3", b_error, b_done, b_code); end
        total++; if (b_addr.size() != 3 || b_ww !== 11'd3) begin bad++; $display("FAIL csum_writes got=%0d ww%0d want=3 ww3", b_addr.size(), b_ww); end
    endtask

    task automatic test_full_capacity();
        logic [31:0] w, sum;
        clear_logs();
        sum = 32'd0;
        pulse_start();
        send_word(32'hB00710AD, 2);
        send_word(32'd16, 2);
        for (int i = 0; i < 16; i++) begin
            w = 32'hA5F00000 + 32'(i) * 32'h01030507;
            sum = sum + w;
            send_word(w, 2);
        end
        send_word(sum, 2);
        total++; if (m_done !== 1'b1 || m_error !== 1'b0 || m_ww !== 5'd16)
            begin bad++; $display("FAIL full_small got=done%b err%b ww%0d want=done1 err0 ww16", m_done, m_error, m_ww); end
        total++; if (b_done !== 1'b1 || b_ww !== 11'd16) begin bad++; $display("FAIL full_big got=done%b ww%0d want=done1 ww16", b_done, b_ww); end
        total++; if (m_addr.size() != 16) begin bad++; $display("FAIL full_write_count got=%0d want=16", m_addr.size()); end
        else for (int i = 0; i < 16; i++) begin
            w = 32'hA5F00000 + 32'(i) * 32'h01030507;
            total++;
            if (m_addr[i] !== 4'(i) || m_data[i] !== w)
                begin bad++; $display("FAIL full_write_%0d got=%h@%0d want=%h@%0d", i, m_data[i], m_addr[i], w, i); end
        end
    endtask

    task automatic test_reset_mid_data();
        clear_logs();
        pulse_start();
        send_word(32'hB00710AD, 0);
        send_word(32'd3, 0);
        send_word(32'h11223344, 0);
        send_byte(8'h88);
        send_byte(8'h77);
        rst_n = 1'b0;
        #2;
        total++; if ({b_busy, if_big.s_ready, if_big.mem_we} !== 3'b000 || b_ww !== 11'd0)
            begin bad++; $display("FAIL rst_async got=busy%b rdy%b we%b ww%0d want=0 0 0 0", b_busy, if_big.s_ready, if_big.mem_we, b_ww); end
        total++; if (b_addr.size() != 1) begin bad++; $display("FAIL rst_partial_writes got=%0d want=1", b_addr.size()); end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        clear_logs();
        pulse_start();
        send_good_frame(32'h00336698);
        total++; if (b_done !== 1'b1 || b_error !== 1'b0 || b_ww !== 11'd3)
            begin bad++; $display("FAIL rst_reload got=done%b err%b ww%0d want=1 0 3", b_done, b_error, b_ww); end
        total++; if (b_addr.size() != 3) begin bad++; $display("FAIL rst_reload_count got=%0d want=3", b_addr.size()); end
        else if (b_addr[0] !== 10'd0 || b_data[0] !== 32'h11223344 || b_addr[2] !== 10'd2 || b_data[2] !== 32'h99AABBCC)
            begin bad++; $display("FAIL rst_reload_data got=%h@%0d %h@%0d", b_data[0], b_addr[0], b_data[2], b_addr[2]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle();
        test_reset();
        test_good_frame();
        test_bad_magic();
        test_bad_length();
        test_csum_mismatch();
        test_full_capacity();
        test_reset_mid_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
